// File: rtl/hazard_control_unit.sv
// Pipeline hazard sequencer: load-use stalls, branch flushes and data-memory waits.
// Also keeps saturating stall/flush counters and a sticky memory-timeout flag.
module hazard_control_unit #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1_de,
  input  logic [4:0]       rs2_de,
  input  logic             rs1_used_de,
  input  logic             rs2_used_de,
  input  logic [4:0]       rd_ex,
  input  logic             MemRd_ex,
  input  logic             NextPCSrc_ex,
  input  logic             dmem_req_me,
  input  logic             dmem_ready,
  output logic             stall_if,
  output logic             stall_de,
  output logic             stall_ex,
  output logic             stall_me,
  output logic             flush_de,
  output logic             flush_ex,
  output logic             flush_wb,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic mem_wait_req, load_use;
  logic freeze, br_flush, bubble;

  assign mem_wait_req = dmem_req_me & ~dmem_ready;
  assign load_use = MemRd_ex & (rd_ex != 5'd0) &
    ((rs1_used_de & (rd_ex == rs1_de)) |
     (rs2_used_de & (rd_ex == rs2_de)));

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    err_d    = err_q;
    freeze   = 1'b0;
    br_flush = 1'b0;
    bubble   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_wait_req) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
          wait_d  = 8'd1;
        end else if (NextPCSrc_ex) begin
          br_flush = 1'b1;
        end else if (load_use) begin
          bubble = 1'b1;
        end
      end
      MEM_WAIT: begin
        // A dropped request ends the wait just like a ready response.
        if (!mem_wait_req) begin
          state_d = RUN;
        end else if (wait_q < 8'(MEM_TIMEOUT)) begin
          freeze = 1'b1;
          wait_d = wait_q + 8'd1;
        end else begin
          err_d   = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs are forced low for the whole time reset is held.
  assign stall_if = rst_n & (freeze | bubble);
  assign stall_de = rst_n & (freeze | bubble);
  assign stall_ex = rst_n & freeze;
  assign stall_me = rst_n & freeze;
  assign flush_de = rst_n & br_flush;
  assign flush_ex = rst_n & (br_flush | bubble);
  assign flush_wb = rst_n & freeze;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_q      <= 8'd0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      if (stall_if && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if ((flush_de || flush_ex) && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign mem_err   = err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
